// File: rtl/ar_bus_arbiter.sv
// Round-robin owner of the address register and memory port for fetch, execute and I/O.
// Each grant runs LOAD -> ACCESS (MEM_LAT cycles) -> DONE and then returns to IDLE for one cycle.
module ar_bus_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  REST,
    // Handshake: requester i raises req[i] and holds it until done[i]. The bus samples we/addr/wdata
    // once, at grant. gnt is one-hot from LOAD through DONE. done pulses for exactly one cycle.
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ar_load,
    output logic [ADDR_W-1:0]     ar_din,
    input  logic [ADDR_W-1:0]     ar_dout,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [1:0]            o_dbg_state,
    output logic [1:0]            o_dbg_rr_ptr
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            r_state, w_state_n;
    logic [3:0]        r_cnt, w_cnt_n;
    logic [1:0]        r_rr, w_rr_n;
    logic [1:0]        r_owner, w_owner_n;
    logic              r_we, w_we_n;
    logic [DATA_W-1:0] r_wdata, w_wdata_n;
    logic [DATA_W-1:0] r_rdata, w_rdata_n;
    logic [ADDR_W-1:0] r_ar_din, w_ar_din_n;
    logic [2:0]        r_gnt, w_gnt_n;
    logic [2:0]        r_done, w_done_n;
    logic              r_ar_load, w_ar_load_n;
    logic              r_mem_rd, w_mem_rd_n;
    logic              r_mem_wr, w_mem_wr_n;
    logic              r_busy, w_busy_n;

    logic              w_found;
    logic [1:0]        w_pick;
    logic [2:0]        w_sum;
    logic [1:0]        w_j;
    logic              w_pick_we;
    logic [ADDR_W-1:0] w_pick_addr;
    logic [DATA_W-1:0] w_pick_wdata;
    logic [ADDR_W-1:0] w_addr_arr  [3];
    logic [DATA_W-1:0] w_wdata_arr [3];
    logic              w_unused_ar_dout;

    // The memory takes its address straight from the address register, so the arbiter ignores it.
    assign w_unused_ar_dout = ^ar_dout;

    for (genvar g = 0; g < 3; g++) begin : g_slice
        assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
    end

    // First requesting index at or after r_rr, wrapping modulo 3.
    always_comb begin : pick
        w_found      = 1'b0;
        w_pick       = 2'd0;
        w_sum        = 3'd0;
        w_j          = 2'd0;
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            w_sum = {1'b0, r_rr} + 3'(k);
            w_j   = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_found && req[w_j]) begin
                w_found      = 1'b1;
                w_pick       = w_j;
                w_pick_we    = we[w_j];
                w_pick_addr  = w_addr_arr[w_j];
                w_pick_wdata = w_wdata_arr[w_j];
            end
        end
    end

    always_comb begin : fsm_next
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_rr_n      = r_rr;
        w_owner_n   = r_owner;
        w_we_n      = r_we;
        w_wdata_n   = r_wdata;
        w_rdata_n   = r_rdata;
        w_ar_din_n  = r_ar_din;
        w_gnt_n     = r_gnt;
        w_done_n    = 3'b000;
        w_ar_load_n = 1'b0;
        w_mem_rd_n  = 1'b0;
        w_mem_wr_n  = 1'b0;
        w_busy_n    = r_busy;
        unique case (r_state)
            S_IDLE: begin
                w_gnt_n  = 3'b000;
                w_busy_n = 1'b0;
                if (w_found) begin
                    w_state_n   = S_LOAD;
                    w_owner_n   = w_pick;
                    w_we_n      = w_pick_we;
                    w_wdata_n   = w_pick_wdata;
                    w_ar_din_n  = w_pick_addr;
                    w_gnt_n     = 3'b001 << w_pick;
                    w_ar_load_n = 1'b1;
                    w_busy_n    = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_n  = S_ACCESS;
                w_cnt_n    = LAT_M1;
                w_mem_rd_n = ~r_we;
                w_mem_wr_n = r_we;
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_n = S_DONE;
                    w_done_n  = 3'b001 << r_owner;
                    if (!r_we) begin
                        w_rdata_n = mem_rdata;
                    end
                end else begin
                    w_cnt_n    = r_cnt - 4'd1;
                    w_mem_rd_n = ~r_we;
                    w_mem_wr_n = r_we;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_rr_n    = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
                w_gnt_n   = 3'b000;
                w_busy_n  = 1'b0;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge REST) begin
        if (!REST) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_rr      <= 2'd0;
            r_owner   <= 2'd0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_ar_din  <= '0;
            r_gnt     <= 3'b000;
            r_done    <= 3'b000;
            r_ar_load <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_rr      <= w_rr_n;
            r_owner   <= w_owner_n;
            r_we      <= w_we_n;
            r_wdata   <= w_wdata_n;
            r_rdata   <= w_rdata_n;
            r_ar_din  <= w_ar_din_n;
            r_gnt     <= w_gnt_n;
            r_done    <= w_done_n;
            r_ar_load <= w_ar_load_n;
            r_mem_rd  <= w_mem_rd_n;
            r_mem_wr  <= w_mem_wr_n;
            r_busy    <= w_busy_n;
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign ar_load      = r_ar_load;
    assign ar_din       = r_ar_din;
    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign busy         = r_busy;
    // Only path that is not registered: the latched write word gated by the write strobe.
    assign mem_wdata    = r_mem_wr ? r_wdata : '0;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr;

endmodule

// File: tb/tb_ar_bus_arbiter.sv
// Bench for ar_bus_arbiter: transaction-level reference model, directed cases, random traffic,
// and a second MEM_LAT=1 instance for the latching/latency case.
module tb_ar_bus_arbiter;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (MEM_LAT = 2) ----------------
    logic [2:0]      req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, done;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            ar_load, mem_rd, mem_wr, busy;
    logic [AW-1:0]   ar_din, ar_q;
    logic [1:0]      dbg_state, dbg_rr;

    ar_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .REST(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .ar_load(ar_load), .ar_din(ar_din),
        .ar_dout(ar_q), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_rr)
    );

    logic [DW-1:0] bus_mem [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    always @(posedge clk) if (ar_load) ar_q <= ar_din;
    always @(posedge clk) if (mem_wr) bus_mem[ar_q] <= mem_wdata;
    assign mem_rdata = mem_rd ? bus_mem[ar_q] : '0;

    // ---------------- DUT B (MEM_LAT = 1) ----------------
    logic [2:0]      req_b, we_b;
    logic [3*AW-1:0] addr_b;
    logic [3*DW-1:0] wdata_b;
    logic [2:0]      gnt_b, done_b;
    logic [DW-1:0]   rdata_b, mem_wdata_b, mem_rdata_b;
    logic            ar_load_b, mem_rd_b, mem_wr_b, busy_b;
    logic [AW-1:0]   ar_din_b, ar_q_b;
    logic [1:0]      dbg_state_b, dbg_rr_b;

    ar_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
        .clk(clk), .REST(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .ar_load(ar_load_b), .ar_din(ar_din_b),
        .ar_dout(ar_q_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b), .o_dbg_state(dbg_state_b), .o_dbg_rr_ptr(dbg_rr_b)
    );

    always @(posedge clk) if (ar_load_b) ar_q_b <= ar_din_b;
    assign mem_rdata_b = mem_rd_b ? ((ar_q_b == 12'h123) ? 16'hCAFE : 16'h0BAD) : '0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each grant expands into a list of expected per-cycle bus views.
    typedef struct packed {
        logic [2:0]    gnt;
        logic [2:0]    done;
        logic          ar_load;
        logic [AW-1:0] ar_din;
        logic          mem_rd;
        logic          mem_wr;
        logic [DW-1:0] mem_wdata;
        logic          busy;
        logic [DW-1:0] rdata;
        logic [AW-1:0] maddr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    logic [1:0]    m_rr;
    logic [DW-1:0] m_rdata;

    function automatic exp_t idle_exp(input logic [DW-1:0] rd);
        exp_t e;
        e = '0;
        e.rdata = rd;
        return e;
    endfunction

    task automatic schedule();
        int o, j;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d, old_rd;
        exp_t e;
        o = -1;
        for (int k = 0; k < 3; k++) begin
            j = (int'(m_rr) + k) % 3;
            if (o < 0 && req[j]) o = j;
        end
        w = we[o];
        a = addr[o*AW +: AW];
        d = wdata[o*DW +: DW];
        old_rd = m_rdata;
        if (w) ref_mem[a] = d;
        else m_rdata = ref_mem[a];
        e = '0;
        e.gnt = 3'b001 << o;
        e.busy = 1'b1;
        e.rdata = old_rd;
        e.ar_load = 1'b1;
        e.ar_din = a;
        exp_q.push_back(e);
        e.ar_load = 1'b0;
        e.ar_din = '0;
        e.mem_rd = !w;
        e.mem_wr = w;
        e.mem_wdata = w ? d : '0;
        e.maddr = a;
        repeat (LAT) exp_q.push_back(e);
        e.mem_rd = 1'b0;
        e.mem_wr = 1'b0;
        e.mem_wdata = '0;
        e.maddr = '0;
        e.done = 3'b001 << o;
        e.rdata = m_rdata;
        exp_q.push_back(e);
        m_rr = 2'((o + 1) % 3);
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_rr = 2'd0;
                m_rdata = '0;
                cur = idle_exp(m_rdata);
            end else begin
                if (!cur.busy && req != 3'b000) schedule();
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = idle_exp(m_rdata);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                chk("gnt", gnt, cur.gnt);
                chk("done", done, cur.done);
                chk("ar_load", ar_load, cur.ar_load);
                chk("mem_rd", mem_rd, cur.mem_rd);
                chk("mem_wr", mem_wr, cur.mem_wr);
                chk("mem_wdata", mem_wdata, cur.mem_wdata);
                chk("busy", busy, cur.busy);
                chk("rdata", rdata, cur.rdata);
                if (cur.ar_load) chk("ar_din", ar_din, cur.ar_din);
                if (cur.mem_rd || cur.mem_wr) chk("mem_addr", ar_q, cur.maddr);
                if (!cur.busy) chk("rr_ptr", dbg_rr, m_rr);
                chk("rd_wr_excl", mem_rd & mem_wr, 0);
                chk("gnt_onehot0", ($countones(gnt) <= 1), 1);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_done(input int i, input string nm);
        int n;
        n = 0;
        while (n < 20) begin
            tick();
            #3;
            if (done[i]) break;
            n++;
        end
        chk(nm, done[i], 1);
        req[i] = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 12'hFFF;
        return AW'($urandom_range(0, 15));
    endfunction

    int rr_exp [6] = '{0, 1, 2, 0, 1, 2};
    int rr_got[$];
    int rr_cyc[$];
    int ndone;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [DW-1:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = DW'($urandom);
            bus_mem[i] = v;
            ref_mem[i] = v;
        end
        bus_mem[12'h0A5] = 16'h1234;
        ref_mem[12'h0A5] = 16'h1234;
        req = '0; we = '0; addr = '0; wdata = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        ar_q = '0; ar_q_b = '0;

        // Reset values
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_ar_load", ar_load, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ar_din", ar_din, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rr", dbg_rr, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Single read by requester 0
        tick(); drive_req(0, 1'b0, 12'h0A5, 16'h0);
        tick(); #3;
        chk("rd_gnt", gnt, 3'b001);
        chk("rd_ar_load", ar_load, 1);
        chk("rd_ar_din", ar_din, 12'h0A5);
        tick(); #3;
        chk("rd_mem_rd1", mem_rd, 1);
        chk("rd_addr", ar_q, 12'h0A5);
        tick(); #3;
        chk("rd_mem_rd2", mem_rd, 1);
        chk("rd_no_early_done", done, 0);
        tick(); #3;
        chk("rd_done", done, 3'b001);
        chk("rd_rdata", rdata, 16'h1234);
        chk("rd_mem_rd_off", mem_rd, 0);
        req[0] = 1'b0;
        tick(); #3;
        chk("rd_idle_gnt", gnt, 0);

        // Single write by requester 1
        tick(); drive_req(1, 1'b1, 12'hFFF, 16'hBEEF);
        tick(); #3;
        chk("wr_gnt", gnt, 3'b010);
        for (int c = 0; c < 2; c++) begin
            tick(); #3;
            chk("wr_mem_wr", mem_wr, 1);
            chk("wr_mem_rd", mem_rd, 0);
            chk("wr_wdata", mem_wdata, 16'hBEEF);
            chk("wr_addr", ar_q, 12'hFFF);
        end
        tick(); #3;
        chk("wr_done", done, 3'b010);
        chk("wr_mem_rd_done", mem_rd, 0);
        req[1] = 1'b0;
        tick(); #3;
        chk("wr_stored", bus_mem[12'hFFF], 16'hBEEF);

        // Pointer resume: rr_ptr=2 wraps to requester 0 before requester 1
        tick();
        drive_req(0, 1'b0, 12'h0A5, 16'h0);
        drive_req(1, 1'b0, 12'h010, 16'h0);
        tick(); #3;
        chk("resume_first", gnt, 3'b001);
        wait_done(0, "resume_done0");
        tick();
        tick(); #3;
        chk("resume_second", gnt, 3'b010);
        wait_done(1, "resume_done1");

        // Reset in the middle of a write access
        tick(); drive_req(0, 1'b1, 12'h800, 16'h1111);
        tick();
        tick();
        chk("mid_rst_wr_before", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", mem_wr, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        req = '0;
        tick(); #3;
        chk("mid_rst_no_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick(); #3;
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_rr", dbg_rr, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        // Round robin with all three requests held
        tick();
        for (int i = 0; i < 3; i++) drive_req(i, 1'b0, AW'(i + 1), 16'h0);
        ndone = 0;
        for (int c = 0; c < 60 && ndone < 6; c++) begin
            tick(); #3;
            if (ar_load) begin
                rr_got.push_back(gnt[0] ? 0 : gnt[1] ? 1 : gnt[2] ? 2 : 7);
                rr_cyc.push_back(c);
            end
            if (done != 3'b000) begin
                ndone++;
                if (ndone == 6) req = '0;
            end
        end
        chk("rr_count", rr_got.size(), 6);
        for (int i = 0; i < 6 && i < rr_got.size(); i++)
            chk($sformatf("rr_order%0d", i), rr_got[i], rr_exp[i]);
        for (int i = 1; i < 6 && i < rr_cyc.size(); i++)
            chk($sformatf("rr_gap%0d", i), rr_cyc[i] - rr_cyc[i-1], 5);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (req[i] && gnt[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0)
                    drive_req(i, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                else if ($urandom_range(0, 3) == 0) begin
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i*AW +: AW] = rand_addr();
                    wdata[i*DW +: DW] = DW'($urandom);
                end
            end
        end
        req = '0;
        repeat (10) tick();

        // MEM_LAT=1 instance: address change during LOAD is ignored; done 4 cycles from grant sample
        tick();
        req_b[0] = 1'b1;
        we_b[0] = 1'b0;
        addr_b[AW-1:0] = 12'h123;
        tick(); #3;
        chk("l1_gnt", gnt_b, 3'b001);
        chk("l1_ar_load", ar_load_b, 1);
        chk("l1_ar_din", ar_din_b, 12'h123);
        chk("l1_no_done_load", done_b, 0);
        addr_b[AW-1:0] = 12'h555;
        tick(); #3;
        chk("l1_mem_rd", mem_rd_b, 1);
        chk("l1_mem_wr", mem_wr_b, 0);
        chk("l1_addr", ar_q_b, 12'h123);
        chk("l1_no_done_acc", done_b, 0);
        tick(); #3;
        chk("l1_done", done_b, 3'b001);
        chk("l1_rdata", rdata_b, 16'hCAFE);
        chk("l1_mem_rd_off", mem_rd_b, 0);
        chk("l1_wdata", mem_wdata_b, 0);
        req_b = '0;
        tick(); #3;
        chk("l1_idle_gnt", gnt_b, 0);
        chk("l1_idle_busy", busy_b, 0);
        chk("l1_idle_state", dbg_state_b, 0);
        chk("l1_rr", dbg_rr_b, 1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ar_bus_arbiter.md
Name: ar_bus_arbiter

Overview:
- Shares the 12-bit address register and the single memory port between three requesters: instruction fetch (0), operand execute (1) and I/O / interrupt save (2).
- Arbitrates with a round-robin scheme and drives the address register's load strobe and data input.
- Issues a fixed-latency memory read or write and returns a one-cycle done pulse to the owning requester.
- Sits between the control unit and the address register / memory in the CPU datapath.

Parameters:
- ADDR_W, 12, address width; equals the address register width.
- DATA_W, 16, memory word width.
- MEM_LAT, 2, memory access cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- REST  in  1  asynchronous, active-low reset.
- req  in  3  request per requester; held high until that requester's done.
- we  in  3  per-requester write enable; sampled at grant.
- addr  in  3*ADDR_W  per-requester address; slice i belongs to requester i.
- wdata  in  3*DATA_W  per-requester write data.
- gnt  out  3  one-hot current owner; 0 when idle.
- done  out  3  one-cycle pulse to the owner at completion.
- rdata  out  DATA_W  read data; valid in the done cycle.
- ar_load  out  1  load strobe to the address register.
- ar_din  out  ADDR_W  address to the address register.
- ar_dout  in  ADDR_W  address register output; drives the memory address.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid on the last access cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (REST=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - gnt, done, ar_load, mem_rd, mem_wr, busy all 0.
  - rdata, ar_din, mem_wdata all 0.
  - Reset release is taken synchronously at the next clk edge.
- States: IDLE, LOAD, ACCESS, DONE.
- IDLE:
  - If any req bit is high, pick the first requester at or after rr_ptr, cyclically (rr_ptr, rr_ptr+1 mod 3, rr_ptr+2 mod 3).
  - Register the owner's index, we, addr and wdata; set gnt one-hot; go to LOAD.
  - With no request, stay in IDLE.
- LOAD (1 cycle):
  - ar_load=1 and ar_din=latched address.
  - The address register captures the address at the end of this cycle.
  - Go to ACCESS with the access counter set to MEM_LAT-1.
- ACCESS (MEM_LAT cycles):
  - mem_rd=~we_l or mem_wr=we_l, held steady for all MEM_LAT cycles.
  - mem_wdata=latched wdata on writes; 0 on reads.
  - The memory address comes from ar_dout, which is stable from the first ACCESS cycle.
  - On the last cycle (counter=0), capture mem_rdata into rdata on reads; go to DONE.
- DONE (1 cycle):
  - done[owner]=1 and gnt is still asserted.
  - rdata holds the captured value for a read, and is unchanged for a write.
  - rr_ptr=(owner+1) mod 3; go to IDLE.
  - gnt drops to 0 in the next IDLE cycle.
- No back-to-back grant: at least one IDLE cycle separates transactions. Per-transaction latency from grant is 1 + 1 + MEM_LAT + 1 cycles, so MEM_LAT=2 gives 5 cycles from the first IDLE sample to the done pulse.
- Request-input rules:
  - Changes to addr/we/wdata after grant are ignored, since everything is latched.
  - Deasserting req mid-transaction does not abort it; done still pulses.
  - Requests arriving during a transaction wait; they are evaluated only in IDLE.
- Fairness: with all three req held continuously, grants rotate 0,1,2,0,… Wait is bounded to 2 transactions.
- Reset mid-transaction: immediate return to IDLE with all strobes deasserted. No done pulse is issued and rr_ptr returns to 0.
- Outputs are registered, with one exception: mem_wdata is combinational from the latched wdata.
- Invariants:
  - mem_rd and mem_wr are never both 1.
  - ar_load is 1 only in LOAD.
  - gnt has at most one bit set.
  - done is 1 only in DONE, on the owner bit only.

Test Plan:
- Reset: assert REST=0 mid-ACCESS of a write → mem_wr and gnt drop to 0 asynchronously; no done pulse; after release, state=IDLE and rr_ptr=0.
- Single read: req=3'b001, addr0=12'h0A5, we=0, mem model returns 16'h1234 → ar_load with ar_din=12'h0A5 in cycle 2, mem_rd for 2 cycles, done[0] with rdata=16'h1234 in cycle 5.
- Single write: req=3'b010, addr1=12'hFFF, wdata1=16'hBEEF, we=1 → mem_wr high 2 cycles with mem_wdata=16'hBEEF, memory address=12'hFFF; done[1]; mem_rd never asserted.
- Round-robin: req=3'b111 held for 6 transactions → grant order 0,1,2,0,1,2, with exactly one IDLE cycle between transactions.
- Pointer resume: after owner 1 completes, raise req=3'b011 → requester 0 is granted before 1, since rr_ptr=2 wraps to 0; then requester 1 is granted.
- Latency and latching: MEM_LAT=1 build; change addr0 to 12'h555 in the LOAD cycle → the address register still loads the original address, and done arrives 4 cycles after grant.
